// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: wait-state controller between the Core and its instruction
// (ROM) and data (RAM) memories. Each channel counts out its WAIT cycles,
// issues the access exactly once, then parks its read data until the Core
// is released. Channel index 0 is ROM, channel index 1 is RAM.
module mem_wait_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 4,
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 3,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cycles,
  input  logic              c_rom_en,
  input  logic [SEL_W-1:0]  c_rom_write_en,
  input  logic [ADDR_W-1:0] c_rom_addr,
  input  logic [DATA_W-1:0] c_rom_wdata,
  output logic [DATA_W-1:0] c_rom_rdata,
  output logic              m_rom_en,
  output logic [SEL_W-1:0]  m_rom_write_en,
  output logic [ADDR_W-1:0] m_rom_addr,
  output logic [DATA_W-1:0] m_rom_wdata,
  input  logic [DATA_W-1:0] m_rom_rdata,
  input  logic              c_ram_en,
  input  logic [SEL_W-1:0]  c_ram_write_en,
  input  logic [ADDR_W-1:0] c_ram_addr,
  input  logic [DATA_W-1:0] c_ram_wdata,
  output logic [DATA_W-1:0] c_ram_rdata,
  output logic              m_ram_en,
  output logic [SEL_W-1:0]  m_ram_write_en,
  output logic [ADDR_W-1:0] m_ram_addr,
  output logic [DATA_W-1:0] m_ram_wdata,
  input  logic [DATA_W-1:0] m_ram_rdata
);

  typedef enum logic [1:0] { IDLE, BUSY, DONE } ch_state_t;

  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);

  logic [1:0]        c_en;
  logic [3:0]        wait_cyc [2];
  logic [DATA_W-1:0] m_rdata  [2];

  ch_state_t         state      [2];
  logic [3:0]        cnt        [2];
  logic [DATA_W-1:0] hold       [2];
  logic              done_first [2];

  logic [1:0]        ch_stall;
  logic [1:0]        issue;

  assign c_en        = {c_ram_en, c_rom_en};
  assign wait_cyc[0] = ROM_W;
  assign wait_cyc[1] = RAM_W;
  assign m_rdata[0]  = m_rom_rdata;
  assign m_rdata[1]  = m_ram_rdata;

  // Decode each channel into "still waiting" or "issue this cycle"; both are forced low in reset
  always_comb begin
    ch_stall = '0;
    issue    = '0;
    for (int i = 0; i < 2; i++) begin
      if (rst && c_en[i]) begin
        case (state[i])
          IDLE: begin
            if (wait_cyc[i] == 4'd0) issue[i] = 1'b1;
            else                     ch_stall[i] = 1'b1;
          end
          BUSY: begin
            if (cnt[i] == 4'd0) issue[i] = 1'b1;
            else                ch_stall[i] = 1'b1;
          end
          default: begin
            ch_stall[i] = 1'b0;
          end
        endcase
      end
    end
  end

  assign stall = (|ch_stall) | ext_stall;

  // Per-channel wait FSM: count down, issue once, then park in DONE until the Core is released
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        state[i]      <= IDLE;
        cnt[i]        <= '0;
        hold[i]       <= '0;
        done_first[i] <= 1'b0;
      end else begin
        done_first[i] <= 1'b0;
        if (issue[i]) begin
          if (stall) begin
            state[i]      <= DONE;
            done_first[i] <= 1'b1;
          end else begin
            state[i] <= IDLE;
          end
        end else begin
          case (state[i])
            IDLE: begin
              if (c_en[i]) begin
                cnt[i]   <= wait_cyc[i] - 4'd1;
                state[i] <= BUSY;
              end
            end
            BUSY: begin
              if (!c_en[i]) state[i] <= IDLE;
              else          cnt[i]   <= cnt[i] - 4'd1;
            end
            DONE: begin
              if (done_first[i]) hold[i]  <= m_rdata[i];
              if (!stall)        state[i] <= IDLE;
            end
            default: begin
              state[i] <= IDLE;
            end
          endcase
        end
      end
    end
  end

  // Saturating count of every cycle the Core spends stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign m_rom_en       = issue[0];
  assign m_rom_write_en = issue[0] ? c_rom_write_en : '0;
  assign m_rom_addr     = c_rom_addr;
  assign m_rom_wdata    = c_rom_wdata;
  assign c_rom_rdata    = (state[0] == DONE && !done_first[0]) ? hold[0] : m_rom_rdata;

  assign m_ram_en       = issue[1];
  assign m_ram_write_en = issue[1] ? c_ram_write_en : '0;
  assign m_ram_addr     = c_ram_addr;
  assign m_ram_wdata    = c_ram_wdata;
  assign c_ram_rdata    = (state[1] == DONE && !done_first[1]) ? hold[1] : m_ram_rdata;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb_mem_wait_ctrl: three controllers with different wait settings share one
// Core-side stimulus stream. dut0 = WAIT 0/0 with a 4-bit counter, dut1 =
// WAIT 2/3, dut2 = WAIT 1/3 with an 8-bit counter.
module tb_mem_wait_ctrl;

  typedef struct {
    bit          rst, ext, rom_en, ram_en;
    logic [3:0]  rom_we, ram_we;
    logic [31:0] rom_addr, ram_addr, rom_wdata, ram_wdata;
    bit          fix_rdata;
    logic [31:0] rom_rdata, ram_rdata;
  } stim_t;

  typedef struct {
    bit         rst, ext, rom_en, ram_en;
    logic [3:0] ram_we;
    logic [2:0] x_stall, x_rom_en, x_ram_en;
  } vec_t;

  logic        clk, rst, ext_stall;
  logic        c_rom_en, c_ram_en;
  logic [3:0]  c_rom_write_en, c_ram_write_en;
  logic [31:0] c_rom_addr, c_ram_addr, c_rom_wdata, c_ram_wdata;
  logic [31:0] m_rom_rdata [3];
  logic [31:0] m_ram_rdata [3];

  logic        stall_o [3];
  logic [31:0] c_rom_rdata_o [3];
  logic [31:0] c_ram_rdata_o [3];
  logic        m_rom_en_o [3];
  logic        m_ram_en_o [3];
  logic [3:0]  m_rom_we_o [3];
  logic [3:0]  m_ram_we_o [3];
  logic [31:0] m_rom_addr_o [3];
  logic [31:0] m_ram_addr_o [3];
  logic [31:0] m_rom_wdata_o [3];
  logic [31:0] m_ram_wdata_o [3];
  logic [3:0]  sc0;
  logic [31:0] sc1;
  logic [7:0]  sc2;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles a request has been held, parked flag, held word
  int          wt     [3][2];
  longint      cmax   [3];
  int          age    [3][2];
  bit          parked [3][2];
  bit          pfirst [3][2];
  logic [31:0] held   [3][2];
  longint      scnt   [3];

  mem_wait_ctrl #(.ROM_WAIT(0), .RAM_WAIT(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .stall(stall_o[0]), .stall_cycles(sc0),
    .c_rom_en(c_rom_en), .c_rom_write_en(c_rom_write_en), .c_rom_addr(c_rom_addr),
    .c_rom_wdata(c_rom_wdata), .c_rom_rdata(c_rom_rdata_o[0]), .m_rom_en(m_rom_en_o[0]),
    .m_rom_write_en(m_rom_we_o[0]), .m_rom_addr(m_rom_addr_o[0]), .m_rom_wdata(m_rom_wdata_o[0]),
    .m_rom_rdata(m_rom_rdata[0]),
    .c_ram_en(c_ram_en), .c_ram_write_en(c_ram_write_en), .c_ram_addr(c_ram_addr),
    .c_ram_wdata(c_ram_wdata), .c_ram_rdata(c_ram_rdata_o[0]), .m_ram_en(m_ram_en_o[0]),
    .m_ram_write_en(m_ram_we_o[0]), .m_ram_addr(m_ram_addr_o[0]), .m_ram_wdata(m_ram_wdata_o[0]),
    .m_ram_rdata(m_ram_rdata[0])
  );

  mem_wait_ctrl #(.ROM_WAIT(2), .RAM_WAIT(3), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .stall(stall_o[1]), .stall_cycles(sc1),
    .c_rom_en(c_rom_en), .c_rom_write_en(c_rom_write_en), .c_rom_addr(c_rom_addr),
    .c_rom_wdata(c_rom_wdata), .c_rom_rdata(c_rom_rdata_o[1]), .m_rom_en(m_rom_en_o[1]),
    .m_rom_write_en(m_rom_we_o[1]), .m_rom_addr(m_rom_addr_o[1]), .m_rom_wdata(m_rom_wdata_o[1]),
    .m_rom_rdata(m_rom_rdata[1]),
    .c_ram_en(c_ram_en), .c_ram_write_en(c_ram_write_en), .c_ram_addr(c_ram_addr),
    .c_ram_wdata(c_ram_wdata), .c_ram_rdata(c_ram_rdata_o[1]), .m_ram_en(m_ram_en_o[1]),
    .m_ram_write_en(m_ram_we_o[1]), .m_ram_addr(m_ram_addr_o[1]), .m_ram_wdata(m_ram_wdata_o[1]),
    .m_ram_rdata(m_ram_rdata[1])
  );

  mem_wait_ctrl #(.ROM_WAIT(1), .RAM_WAIT(3), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .stall(stall_o[2]), .stall_cycles(sc2),
    .c_rom_en(c_rom_en), .c_rom_write_en(c_rom_write_en), .c_rom_addr(c_rom_addr),
    .c_rom_wdata(c_rom_wdata), .c_rom_rdata(c_rom_rdata_o[2]), .m_rom_en(m_rom_en_o[2]),
    .m_rom_write_en(m_rom_we_o[2]), .m_rom_addr(m_rom_addr_o[2]), .m_rom_wdata(m_rom_wdata_o[2]),
    .m_rom_rdata(m_rom_rdata[2]),
    .c_ram_en(c_ram_en), .c_ram_write_en(c_ram_write_en), .c_ram_addr(c_ram_addr),
    .c_ram_wdata(c_ram_wdata), .c_ram_rdata(c_ram_rdata_o[2]), .m_ram_en(m_ram_en_o[2]),
    .m_ram_write_en(m_ram_we_o[2]), .m_ram_addr(m_ram_addr_o[2]), .m_ram_wdata(m_ram_wdata_o[2]),
    .m_ram_rdata(m_ram_rdata[2])
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int idx, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s [%0d] at t=%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  function automatic longint scOf(input int g);
    case (g)
      0:       return longint'(sc0);
      1:       return longint'(sc1);
      default: return longint'(sc2);
    endcase
  endfunction

  function automatic void resetModel();
    for (int g = 0; g < 3; g++) begin
      scnt[g] = 0;
      for (int c = 0; c < 2; c++) begin
        age[g][c]    = 0;
        parked[g][c] = 1'b0;
        pfirst[g][c] = 1'b0;
        held[g][c]   = '0;
      end
    end
  endfunction

  function automatic stim_t mkStim(input bit r, input bit e, input bit romen, input bit ramen,
                                   input logic [3:0] ramwe);
    stim_t s;
    s.rst = r; s.ext = e; s.rom_en = romen; s.ram_en = ramen;
    s.rom_we = 4'h0; s.ram_we = ramwe;
    s.rom_addr = $urandom(); s.ram_addr = $urandom();
    s.rom_wdata = $urandom(); s.ram_wdata = $urandom();
    s.fix_rdata = 1'b0; s.rom_rdata = '0; s.ram_rdata = '0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s = mkStim($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0);
    s.rom_we = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
    return s;
  endfunction

  function automatic vec_t mkVec(input bit r, input bit e, input bit romen, input bit ramen,
                                 input logic [3:0] ramwe, input logic [2:0] xs,
                                 input logic [2:0] xrom, input logic [2:0] xram);
    vec_t v;
    v.rst = r; v.ext = e; v.rom_en = romen; v.ram_en = ramen; v.ram_we = ramwe;
    v.x_stall = xs; v.x_rom_en = xrom; v.x_ram_en = xram;
    return v;
  endfunction

  // Drive one Core cycle, compare all three controllers against the model, advance the model
  task automatic applyStimulus(input stim_t s);
    bit          en  [2];
    bit          cst [2];
    bit          iss [2];
    bit          xs;
    logic [31:0] rin [2];
    @(negedge clk);
    rst = s.rst; ext_stall = s.ext;
    c_rom_en = s.rom_en; c_rom_write_en = s.rom_we; c_rom_addr = s.rom_addr; c_rom_wdata = s.rom_wdata;
    c_ram_en = s.ram_en; c_ram_write_en = s.ram_we; c_ram_addr = s.ram_addr; c_ram_wdata = s.ram_wdata;
    for (int g = 0; g < 3; g++) begin
      m_rom_rdata[g] = s.fix_rdata ? s.rom_rdata : $urandom();
      m_ram_rdata[g] = s.fix_rdata ? s.ram_rdata : $urandom();
    end
    #1;
    en[0] = s.rom_en;
    en[1] = s.ram_en;
    for (int g = 0; g < 3; g++) begin
      rin[0] = m_rom_rdata[g];
      rin[1] = m_ram_rdata[g];
      for (int c = 0; c < 2; c++) begin
        cst[c] = 1'b0;
        iss[c] = 1'b0;
        if (s.rst && !parked[g][c] && en[c]) begin
          if (age[g][c] < wt[g][c]) cst[c] = 1'b1;
          else                      iss[c] = 1'b1;
        end
      end
      xs = s.ext | cst[0] | cst[1];
      if (s.rst) checkOutput("stall", g, stall_o[g], xs);
      checkOutput("m_rom_en", g, m_rom_en_o[g], iss[0]);
      checkOutput("m_ram_en", g, m_ram_en_o[g], iss[1]);
      checkOutput("m_rom_write_en", g, m_rom_we_o[g], iss[0] ? s.rom_we : 4'h0);
      checkOutput("m_ram_write_en", g, m_ram_we_o[g], iss[1] ? s.ram_we : 4'h0);
      checkOutput("c_rom_rdata", g, c_rom_rdata_o[g],
                  (parked[g][0] && !pfirst[g][0]) ? held[g][0] : rin[0]);
      checkOutput("c_ram_rdata", g, c_ram_rdata_o[g],
                  (parked[g][1] && !pfirst[g][1]) ? held[g][1] : rin[1]);
      checkOutput("m_rom_bus", g, {m_rom_addr_o[g], m_rom_wdata_o[g]}, {s.rom_addr, s.rom_wdata});
      checkOutput("m_ram_bus", g, {m_ram_addr_o[g], m_ram_wdata_o[g]}, {s.ram_addr, s.ram_wdata});
      checkOutput("stall_cycles", g, scOf(g), scnt[g]);
      if (s.rst) begin
        if (xs && scnt[g] < cmax[g]) scnt[g]++;
        for (int c = 0; c < 2; c++) begin
          if (parked[g][c]) begin
            if (pfirst[g][c]) held[g][c] = rin[c];
            pfirst[g][c] = 1'b0;
            if (!xs) parked[g][c] = 1'b0;
          end else if (iss[c]) begin
            age[g][c] = 0;
            if (xs) begin
              parked[g][c] = 1'b1;
              pfirst[g][c] = 1'b1;
            end
          end else if (en[c]) begin
            age[g][c]++;
          end else begin
            age[g][c] = 0;
          end
        end
      end
    end
    if (!s.rst) resetModel();
  endtask

  // Main sequence: table, hand-written corner cases, then a random soak
  initial begin
    vec_t        vt [22];
    stim_t       s;
    int          nstall, nwrite;
    logic [31:0] r3;

    wt[0][0] = 0; wt[0][1] = 0; cmax[0] = 64'd15;
    wt[1][0] = 2; wt[1][1] = 3; cmax[1] = 64'hFFFF_FFFF;
    wt[2][0] = 1; wt[2][1] = 3; cmax[2] = 64'd255;

    rst = 1'b0; ext_stall = 1'b0;
    c_rom_en = 1'b0; c_rom_write_en = '0; c_rom_addr = '0; c_rom_wdata = '0;
    c_ram_en = 1'b0; c_ram_write_en = '0; c_ram_addr = '0; c_ram_wdata = '0;
    for (int g = 0; g < 3; g++) begin
      m_rom_rdata[g] = '0;
      m_ram_rdata[g] = '0;
    end
    repeat (2) @(negedge clk);
    resetModel();

    // rst ext rom ram we | stall(dut2..0) rom_en ram_en
    vt[0]  = mkVec(0, 0, 1, 1, 4'hF, 3'b000, 3'b000, 3'b000);
    vt[1]  = mkVec(1, 0, 1, 0, 4'h0, 3'b110, 3'b001, 3'b000);
    vt[2]  = mkVec(1, 0, 1, 0, 4'h0, 3'b010, 3'b101, 3'b000);
    vt[3]  = mkVec(1, 0, 1, 0, 4'h0, 3'b100, 3'b011, 3'b000);
    vt[4]  = mkVec(1, 0, 0, 0, 4'h0, 3'b000, 3'b000, 3'b000);
    vt[5]  = mkVec(1, 0, 0, 0, 4'h0, 3'b000, 3'b000, 3'b000);
    vt[6]  = mkVec(1, 0, 1, 1, 4'hF, 3'b110, 3'b001, 3'b001);
    vt[7]  = mkVec(1, 0, 1, 1, 4'hF, 3'b110, 3'b101, 3'b001);
    vt[8]  = mkVec(1, 0, 1, 1, 4'hF, 3'b110, 3'b011, 3'b001);
    vt[9]  = mkVec(1, 0, 1, 1, 4'hF, 3'b000, 3'b001, 3'b111);
    vt[10] = mkVec(1, 0, 0, 0, 4'h0, 3'b000, 3'b000, 3'b000);
    vt[11] = mkVec(1, 1, 1, 0, 4'h0, 3'b111, 3'b001, 3'b000);
    vt[12] = mkVec(1, 0, 1, 0, 4'h0, 3'b010, 3'b100, 3'b000);
    vt[13] = mkVec(1, 0, 0, 0, 4'h0, 3'b000, 3'b000, 3'b000);
    vt[14] = mkVec(1, 0, 0, 1, 4'h0, 3'b110, 3'b000, 3'b001);
    vt[15] = mkVec(0, 0, 0, 1, 4'h0, 3'b000, 3'b000, 3'b000);
    vt[16] = mkVec(1, 0, 0, 1, 4'h0, 3'b110, 3'b000, 3'b001);
    vt[17] = mkVec(1, 0, 0, 0, 4'h0, 3'b000, 3'b000, 3'b000);
    vt[18] = mkVec(1, 1, 0, 0, 4'h0, 3'b111, 3'b000, 3'b000);
    vt[19] = mkVec(1, 1, 0, 0, 4'h0, 3'b111, 3'b000, 3'b000);
    vt[20] = mkVec(1, 1, 0, 0, 4'h0, 3'b111, 3'b000, 3'b000);
    vt[21] = mkVec(1, 1, 0, 0, 4'h0, 3'b111, 3'b000, 3'b000);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(mkStim(vt[i].rst, vt[i].ext, vt[i].rom_en, vt[i].ram_en, vt[i].ram_we));
      if (vt[i].rst) checkOutput("tbl_stall", i, {stall_o[2], stall_o[1], stall_o[0]}, vt[i].x_stall);
      checkOutput("tbl_m_rom_en", i, {m_rom_en_o[2], m_rom_en_o[1], m_rom_en_o[0]}, vt[i].x_rom_en);
      checkOutput("tbl_m_ram_en", i, {m_ram_en_o[2], m_ram_en_o[1], m_ram_en_o[0]}, vt[i].x_ram_en);
    end

    // Store of 0xDEADBEEF to 0x10 alongside a fetch: ROM word parks while RAM still waits (dut2)
    applyStimulus(mkStim(0, 0, 0, 0, 4'h0));
    nstall = 0;
    nwrite = 0;
    r3     = 32'h1111_0003;
    for (int k = 1; k <= 5; k++) begin
      s = mkStim(1, 0, k < 5, k < 5, (k < 5) ? 4'hF : 4'h0);
      s.rom_addr  = 32'h0;
      s.ram_addr  = 32'h10;
      s.ram_wdata = 32'hDEAD_BEEF;
      s.fix_rdata = 1'b1;
      s.rom_rdata = 32'h1111_0000 + 32'(k);
      s.ram_rdata = 32'h2222_0000 + 32'(k);
      applyStimulus(s);
      if (stall_o[2]) nstall++;
      if (m_ram_we_o[2] != 4'h0) begin
        nwrite++;
        checkOutput("sw_write_en", k, m_ram_we_o[2], 4'hF);
        checkOutput("sw_addr", k, m_ram_addr_o[2], 32'h10);
        checkOutput("sw_wdata", k, m_ram_wdata_o[2], 32'hDEAD_BEEF);
      end
      if (k == 3) checkOutput("fetch_first_done", k, c_rom_rdata_o[2], r3);
      if (k == 4) checkOutput("fetch_held", k, c_rom_rdata_o[2], r3);
      if (k == 5) checkOutput("fetch_released", k, c_rom_rdata_o[2], 32'h1111_0005);
    end
    checkOutput("sw_stall_len", 2, nstall, 3);
    checkOutput("sw_write_count", 2, nwrite, 1);

    // External stall while idle, then a long run to saturate the 4-bit counter
    applyStimulus(mkStim(0, 0, 0, 0, 4'h0));
    repeat (4) applyStimulus(mkStim(1, 1, 0, 0, 4'h0));
    applyStimulus(mkStim(1, 0, 0, 0, 4'h0));
    checkOutput("ext4_sc_dut0", 0, sc0, 4);
    checkOutput("ext4_sc_dut1", 1, sc1, 4);
    checkOutput("ext4_sc_dut2", 2, sc2, 4);
    repeat (16) applyStimulus(mkStim(1, 1, 0, 0, 4'h0));
    applyStimulus(mkStim(1, 0, 0, 0, 4'h0));
    checkOutput("sat_sc_dut0", 0, sc0, 4'hF);
    checkOutput("sat_sc_dut1", 1, sc1, 20);
    checkOutput("sat_sc_dut2", 2, sc2, 20);

    // Random soak against the reference model
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(randStim());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
